// File: rtl/fv_bank_req_arbiter_pkg.sv
// rtl/fv_bank_req_arbiter_pkg.sv - shared types and constants for the FV bank request arbiter
package fv_bank_req_arbiter_pkg;

  // Defaults track Num_Edge_PE, $clog2(Max_Node_id) and FV_bandwidth
  localparam int NUM_PE_DEF    = 4;
  localparam int NODE_ID_W_DEF = 10;
  localparam int DATA_W_DEF    = 64;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WB_BURST = 2'd1,
    ST_RD_WAIT  = 2'd2
  } arb_state_e;

  // PE tag width; a single requester still gets one tag bit
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fv_bank_req_arbiter_if.sv
// rtl/fv_bank_req_arbiter_if.sv - requester and bank request bundle for the FV bank arbiter
interface fv_bank_req_arbiter_if
  import fv_bank_req_arbiter_pkg::*;
#(
  parameter int NUM_PE    = NUM_PE_DEF,
  parameter int NODE_ID_W = NODE_ID_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
);
  localparam int TAG_W = tag_width(NUM_PE);

  // Edge PE read requests, PE0 in the LSBs of rd_node_id
  logic [NUM_PE-1:0]           rd_valid;
  logic [NUM_PE*NODE_ID_W-1:0] rd_node_id;
  logic [NUM_PE-1:0]           rd_ready;

  // Output-buffer write-back stream
  logic                        wb_valid;
  logic [NODE_ID_W-1:0]        wb_node_id;
  logic [DATA_W-1:0]           wb_data;
  logic                        wb_eos;
  logic                        wb_ready;

  // Registered request toward the bank controller
  logic                        bank_req_valid;
  logic                        bank_req_rd_wr;
  logic [NODE_ID_W-1:0]        bank_req_node_id;
  logic [DATA_W-1:0]           bank_req_data;
  logic                        bank_req_wr_eos;
  logic [TAG_W-1:0]            bank_req_pe_tag;

  modport master (
    output rd_valid, rd_node_id, wb_valid, wb_node_id, wb_data, wb_eos,
    input  rd_ready, wb_ready,
    input  bank_req_valid, bank_req_rd_wr, bank_req_node_id, bank_req_data,
    input  bank_req_wr_eos, bank_req_pe_tag
  );

  modport slave (
    input  rd_valid, rd_node_id, wb_valid, wb_node_id, wb_data, wb_eos,
    output rd_ready, wb_ready,
    output bank_req_valid, bank_req_rd_wr, bank_req_node_id, bank_req_data,
    output bank_req_wr_eos, bank_req_pe_tag
  );

endinterface

// File: rtl/fv_bank_req_arbiter_rr_arbiter.sv
// rtl/fv_bank_req_arbiter_rr_arbiter.sv - round-robin one-hot grant starting at a pointer
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  // First requester found walking upward from ptr, wrapping at N
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fv_bank_req_arbiter.sv
// rtl/fv_bank_req_arbiter.sv - serializes Edge PE reads and write-back bursts onto one FV SRAM bank
module fv_bank_req_arbiter
  import fv_bank_req_arbiter_pkg::*;
#(
  parameter int NUM_PE    = NUM_PE_DEF,
  parameter int NODE_ID_W = NODE_ID_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  fv_bank_req_arbiter_if.slave  bus,
  input  logic                  stream_mode,
  input  logic                  bank_rd_eos,
  output logic                  busy,
  output logic                  wb_underrun,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [CNT_W-1:0]      wb_cnt
);

  localparam int TAG_W = tag_width(NUM_PE);

  arb_state_e           state_q, state_d;
  logic [TAG_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 rd_starve_q, rd_starve_d;
  // One idle cycle after any write-back eos reaches the bank
  logic                 eos_gap_q, eos_gap_d;
  logic [NODE_ID_W-1:0] wb_node_q, wb_node_d;

  logic                 req_valid_q, req_valid_d;
  logic                 req_rd_wr_q, req_rd_wr_d;
  logic [NODE_ID_W-1:0] req_node_q, req_node_d;
  logic [DATA_W-1:0]    req_data_q, req_data_d;
  logic                 req_wr_eos_q, req_wr_eos_d;
  logic [TAG_W-1:0]     req_tag_q, req_tag_d;

  logic                 wb_underrun_q, wb_underrun_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]     wb_cnt_q, wb_cnt_d;
  logic                 rd_cnt_inc, wb_cnt_inc;

  logic [NUM_PE-1:0]    rr_gnt;
  logic [TAG_W-1:0]     rr_idx;
  logic                 rr_any;
  logic                 grant_ok, grant_wb, grant_rd;
  logic [NODE_ID_W-1:0] sel_node;

  rr_arbiter #(
    .N  (NUM_PE),
    .PW (TAG_W)
  ) u_rr (
    .req     (bus.rd_valid),
    .ptr     (rr_ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Grant decision: IDLE only, blocked while streaming or in the post-write gap
  always_comb begin
    grant_ok = (state_q == ST_IDLE) && !stream_mode && !eos_gap_q && !reset;
    grant_wb = grant_ok && bus.wb_valid && !(rd_starve_q && rr_any);
    grant_rd = grant_ok && rr_any && !grant_wb;
    sel_node = bus.rd_node_id[int'(rr_idx)*NODE_ID_W +: NODE_ID_W];
  end

  assign bus.rd_ready = grant_rd ? rr_gnt : '0;
  // The bank consumes a write-back beat every burst cycle whether or not it is valid
  assign bus.wb_ready = grant_wb || ((state_q == ST_WB_BURST) && !reset);

  // Next-state and next registered bank request
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    rd_starve_d   = rd_starve_q;
    eos_gap_d     = 1'b0;
    wb_node_d     = wb_node_q;
    req_valid_d   = 1'b0;
    req_rd_wr_d   = req_rd_wr_q;
    req_node_d    = req_node_q;
    req_data_d    = '0;
    req_wr_eos_d  = 1'b0;
    req_tag_d     = req_tag_q;
    wb_underrun_d = wb_underrun_q;
    rd_cnt_inc    = 1'b0;
    wb_cnt_inc    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_wb) begin
          req_valid_d  = 1'b1;
          req_rd_wr_d  = 1'b1;
          req_node_d   = bus.wb_node_id;
          req_data_d   = bus.wb_data;
          req_wr_eos_d = bus.wb_eos;
          if (bus.wb_eos) begin
            wb_cnt_inc  = 1'b1;
            rd_starve_d = 1'b1;
            eos_gap_d   = 1'b1;
          end else begin
            wb_node_d = bus.wb_node_id;
            state_d   = ST_WB_BURST;
          end
        end else if (grant_rd) begin
          req_valid_d = 1'b1;
          req_rd_wr_d = 1'b0;
          req_node_d  = sel_node;
          req_tag_d   = rr_idx;
          rr_ptr_d    = (int'(rr_idx) == NUM_PE - 1) ? '0 : rr_idx + TAG_W'(1);
          rd_starve_d = 1'b0;
          state_d     = ST_RD_WAIT;
        end
      end
      ST_WB_BURST: begin
        // Bank base node stays fixed; the bank advances its own address
        req_valid_d = 1'b1;
        req_rd_wr_d = 1'b1;
        req_node_d  = wb_node_q;
        if (bus.wb_valid) begin
          req_data_d   = bus.wb_data;
          req_wr_eos_d = bus.wb_eos;
          if (bus.wb_eos) begin
            state_d     = ST_IDLE;
            wb_cnt_inc  = 1'b1;
            rd_starve_d = 1'b1;
            eos_gap_d   = 1'b1;
          end
        end else begin
          // Source ran dry: close the bank burst with a zero beat
          req_wr_eos_d  = 1'b1;
          wb_underrun_d = 1'b1;
          state_d       = ST_IDLE;
          rd_starve_d   = 1'b1;
          eos_gap_d     = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (bank_rd_eos) begin
          state_d    = ST_IDLE;
          rd_cnt_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_cnt_d = (rd_cnt_inc && (rd_cnt_q != '1)) ? rd_cnt_q + CNT_W'(1) : rd_cnt_q;
    wb_cnt_d = (wb_cnt_inc && (wb_cnt_q != '1)) ? wb_cnt_q + CNT_W'(1) : wb_cnt_q;
  end

  // State and output registers; reset aborts any burst in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      rd_starve_q   <= 1'b0;
      eos_gap_q     <= 1'b0;
      wb_node_q     <= '0;
      req_valid_q   <= 1'b0;
      req_rd_wr_q   <= 1'b0;
      req_node_q    <= '0;
      req_data_q    <= '0;
      req_wr_eos_q  <= 1'b0;
      req_tag_q     <= '0;
      wb_underrun_q <= 1'b0;
      rd_cnt_q      <= '0;
      wb_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      rd_starve_q   <= rd_starve_d;
      eos_gap_q     <= eos_gap_d;
      wb_node_q     <= wb_node_d;
      req_valid_q   <= req_valid_d;
      req_rd_wr_q   <= req_rd_wr_d;
      req_node_q    <= req_node_d;
      req_data_q    <= req_data_d;
      req_wr_eos_q  <= req_wr_eos_d;
      req_tag_q     <= req_tag_d;
      wb_underrun_q <= wb_underrun_d;
      rd_cnt_q      <= rd_cnt_d;
      wb_cnt_q      <= wb_cnt_d;
    end
  end

  assign bus.bank_req_valid   = req_valid_q;
  assign bus.bank_req_rd_wr   = req_rd_wr_q;
  assign bus.bank_req_node_id = req_node_q;
  assign bus.bank_req_data    = req_data_q;
  assign bus.bank_req_wr_eos  = req_wr_eos_q;
  assign bus.bank_req_pe_tag  = req_tag_q;
  assign busy                 = (state_q != ST_IDLE);
  assign wb_underrun          = wb_underrun_q;
  assign rd_cnt               = rd_cnt_q;
  assign wb_cnt               = wb_cnt_q;

endmodule

// File: tb/tb_fv_bank_req_arbiter.sv
// tb/tb_fv_bank_req_arbiter.sv - self-checking bench for fv_bank_req_arbiter
module tb_fv_bank_req_arbiter;

  localparam int NPE = 4;
  localparam int NW  = 10;
  localparam int DW  = 64;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          stream_mode;
  logic          bank_rd_eos;
  logic          busy;
  logic          wb_underrun;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wb_cnt;

  int checks   = 0;
  int failures = 0;

  fv_bank_req_arbiter_if #(.NUM_PE(NPE), .NODE_ID_W(NW), .DATA_W(DW)) bus ();

  fv_bank_req_arbiter #(
    .NUM_PE(NPE), .NODE_ID_W(NW), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .stream_mode (stream_mode),
    .bank_rd_eos (bank_rd_eos),
    .busy        (busy),
    .wb_underrun (wb_underrun),
    .rd_cnt      (rd_cnt),
    .wb_cnt      (wb_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          stream;
    logic          wbv;
    logic [3:0]    rdv;
    logic [3:0]    exp_rdy;
    logic          exp_wbr;
    logic          exp_v;
    logic          exp_rdwr;
    logic [1:0]    exp_tag;
    logic [NW-1:0] exp_node;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rd_valid   = '0;
    bus.rd_node_id = '0;
    bus.wb_valid   = 1'b0;
    bus.wb_node_id = '0;
    bus.wb_data    = '0;
    bus.wb_eos     = 1'b0;
    stream_mode    = 1'b0;
    bank_rd_eos    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_node(input int pe, input logic [NW-1:0] v);
    bus.rd_node_id[pe*NW +: NW] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, bus.bank_req_valid, 0);
    chk({tag, " rd_wr"}, bus.bank_req_rd_wr, 0);
    chk({tag, " node"}, bus.bank_req_node_id, 0);
    chk({tag, " data"}, bus.bank_req_data, 0);
    chk({tag, " wr_eos"}, bus.bank_req_wr_eos, 0);
    chk({tag, " pe_tag"}, bus.bank_req_pe_tag, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " underrun"}, wb_underrun, 0);
    chk({tag, " rd_cnt"}, rd_cnt, 0);
    chk({tag, " wb_cnt"}, wb_cnt, 0);
    chk({tag, " rd_ready"}, bus.rd_ready, 0);
    chk({tag, " wb_ready"}, bus.wb_ready, 0);
  endtask

  // Reference model state (transaction-level view of the bank ownership)
  int              m_mode;   // 0 free, 1 write-back burst owns bank, 2 read owns bank
  int              m_ptr;
  bit              m_starve, m_gap, m_und, gap_n, g_wb, any_rd;
  int              m_rdc, m_wbc, g_k;
  logic [NW-1:0]   m_wbnode;
  logic            e_valid, e_rdwr, e_eos;
  logic [NW-1:0]   e_node;
  logic [1:0]      e_tag;
  logic [DW-1:0]   e_data;

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("reset");

    // Single-cycle arbitration from reset state: PE p carries node 10*(p+1), write-back node 5
    vecs[0] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 10'd0};
    vecs[1] = '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd2, 10'd30};
    vecs[2] = '{1'b0, 1'b0, 4'b1010, 4'b0010, 1'b0, 1'b1, 1'b0, 2'd1, 10'd20};
    vecs[3] = '{1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0, 2'd3, 10'd40};
    vecs[4] = '{1'b0, 1'b1, 4'b0110, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 10'd5};
    vecs[5] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 10'd0};
    vecs[6] = '{1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 10'd0};
    vecs[7] = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 10'd10};
    vecs[8] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 10'd5};
    for (int i = 0; i < 9; i++) begin
      do_reset();
      for (int p = 0; p < NPE; p++) set_node(p, NW'(10 * (p + 1)));
      bus.wb_node_id = 10'd5;
      bus.wb_data    = 64'hA5;
      bus.wb_eos     = 1'b1;
      stream_mode    = vecs[i].stream;
      bus.wb_valid   = vecs[i].wbv;
      bus.rd_valid   = vecs[i].rdv;
      #1;
      chk($sformatf("vec%0d rd_ready", i), bus.rd_ready, vecs[i].exp_rdy);
      chk($sformatf("vec%0d wb_ready", i), bus.wb_ready, vecs[i].exp_wbr);
      tick();
      chk($sformatf("vec%0d valid", i), bus.bank_req_valid, vecs[i].exp_v);
      if (vecs[i].exp_v) begin
        chk($sformatf("vec%0d rd_wr", i), bus.bank_req_rd_wr, vecs[i].exp_rdwr);
        chk($sformatf("vec%0d node", i), bus.bank_req_node_id, vecs[i].exp_node);
        if (!vecs[i].exp_rdwr) chk($sformatf("vec%0d tag", i), bus.bank_req_pe_tag, vecs[i].exp_tag);
      end
    end

    // Single read: PE2 node 12, eos 4 cycles after the request reaches the bank
    do_reset();
    set_node(2, 10'd12);
    bus.rd_valid = 4'b0100;
    #1;
    chk("single rd_ready", bus.rd_ready, 4'b0100);
    tick();
    bus.rd_valid = '0;
    chk("single valid", bus.bank_req_valid, 1);
    chk("single rd_wr", bus.bank_req_rd_wr, 0);
    chk("single tag", bus.bank_req_pe_tag, 2);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) chk($sformatf("single valid c%0d", c), bus.bank_req_valid, 0);
      chk($sformatf("single node c%0d", c), bus.bank_req_node_id, 12);
      chk($sformatf("single busy c%0d", c), busy, 1);
      bank_rd_eos = (c == 4);
      tick();
    end
    bank_rd_eos = 1'b0;
    chk("single busy end", busy, 0);
    chk("single rd_cnt", rd_cnt, 1);
    bus.rd_valid = 4'b0001;
    #1;
    chk("single next grant", bus.rd_ready, 4'b0001);

    // Round-robin with all PEs requesting continuously
    do_reset();
    bus.rd_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk($sformatf("rr grant %0d", n), bus.rd_ready, 4'b0001 << (n % NPE));
      tick();
      bank_rd_eos = 1'b1;
      chk($sformatf("rr tag %0d", n), bus.bank_req_pe_tag, n % NPE);
      tick();
      bank_rd_eos = 1'b0;
    end
    chk("rr rd_cnt", rd_cnt, 5);

    // Write-back priority and anti-starvation
    do_reset();
    set_node(1, 10'd21);
    bus.rd_valid   = 4'b0010;
    bus.wb_valid   = 1'b1;
    bus.wb_node_id = 10'd8;
    bus.wb_data    = 64'hA;
    #1;
    chk("wb first wb_ready", bus.wb_ready, 1);
    chk("wb first rd_ready", bus.rd_ready, 0);
    tick();
    bus.wb_data = 64'hB;
    chk("wb beatA data", bus.bank_req_data, 64'hA);
    chk("wb beatA node", bus.bank_req_node_id, 8);
    chk("wb beatA rd_wr", bus.bank_req_rd_wr, 1);
    chk("wb beatA eos", bus.bank_req_wr_eos, 0);
    tick();
    bus.wb_data = 64'hC;
    bus.wb_eos  = 1'b1;
    chk("wb beatB valid", bus.bank_req_valid, 1);
    chk("wb beatB data", bus.bank_req_data, 64'hB);
    tick();
    bus.wb_data = 64'hD;
    bus.wb_eos  = 1'b0;
    chk("wb beatC valid", bus.bank_req_valid, 1);
    chk("wb beatC data", bus.bank_req_data, 64'hC);
    chk("wb beatC eos", bus.bank_req_wr_eos, 1);
    chk("wb beatC node", bus.bank_req_node_id, 8);
    chk("wb wb_cnt", wb_cnt, 1);
    #1;
    chk("wb gap grants", {bus.rd_ready, bus.wb_ready}, 0);
    tick();
    chk("wb gap valid", bus.bank_req_valid, 0);
    #1;
    chk("starve rd_ready", bus.rd_ready, 4'b0010);
    chk("starve wb_ready", bus.wb_ready, 0);
    tick();
    bus.rd_valid = '0;
    chk("starve rd valid", bus.bank_req_valid, 1);
    chk("starve rd rd_wr", bus.bank_req_rd_wr, 0);
    chk("starve rd tag", bus.bank_req_pe_tag, 1);
    chk("starve rd node", bus.bank_req_node_id, 21);
    bank_rd_eos = 1'b1;
    tick();
    bank_rd_eos = 1'b0;
    #1;
    chk("wb after read", bus.wb_ready, 1);

    // Stream block: nothing granted for 20 cycles, then grant as soon as it drops
    do_reset();
    stream_mode  = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_eos   = 1'b1;
    bus.rd_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk($sformatf("stream c%0d", c), {bus.rd_ready, bus.wb_ready, bus.bank_req_valid}, 0);
      tick();
    end
    stream_mode = 1'b0;
    #1;
    chk("stream release wb_ready", bus.wb_ready, 1);
    tick();
    chk("stream release valid", bus.bank_req_valid, 1);

    // Underrun on beat 2 of a 4-beat burst
    do_reset();
    bus.wb_valid   = 1'b1;
    bus.wb_node_id = 10'd100;
    bus.wb_data    = 64'h11;
    tick();
    bus.wb_data = 64'h22;
    tick();
    bus.wb_valid = 1'b0;
    bus.wb_data  = 64'hFF;
    #1;
    chk("under wb_ready", bus.wb_ready, 1);
    chk("under beat1 data", bus.bank_req_data, 64'h22);
    tick();
    chk("under valid", bus.bank_req_valid, 1);
    chk("under rd_wr", bus.bank_req_rd_wr, 1);
    chk("under data", bus.bank_req_data, 0);
    chk("under wr_eos", bus.bank_req_wr_eos, 1);
    chk("under node", bus.bank_req_node_id, 100);
    chk("under flag", wb_underrun, 1);
    chk("under busy", busy, 0);
    tick();
    tick();
    chk("under sticky", wb_underrun, 1);
    chk("under wb_cnt", wb_cnt, 0);

    // Reset in RD_WAIT
    do_reset();
    set_node(0, 10'd10);
    bus.rd_valid = 4'b0001;
    tick();
    bus.rd_valid = '0;
    tick();
    chk("rstrd busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("rstrd");
    bus.rd_valid = 4'b1111;
    #1;
    chk("rstrd ptr", bus.rd_ready, 4'b0001);

    // Randomized run against the transaction-level model
    do_reset();
    m_mode = 0; m_ptr = 0; m_starve = 0; m_gap = 0; m_und = 0; m_rdc = 0; m_wbc = 0;
    m_wbnode = '0; e_valid = 0; e_rdwr = 0; e_eos = 0; e_node = '0; e_tag = '0; e_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd valid", bus.bank_req_valid, e_valid);
      if (e_valid && e_rdwr) begin
        chk("rnd wr node", bus.bank_req_node_id, e_node);
        chk("rnd wr data", bus.bank_req_data, e_data);
        chk("rnd wr eos", bus.bank_req_wr_eos, e_eos);
      end else if (e_valid || m_mode == 2) begin
        chk("rnd rd rd_wr", bus.bank_req_rd_wr, 0);
        chk("rnd rd node", bus.bank_req_node_id, e_node);
        chk("rnd rd tag", bus.bank_req_pe_tag, e_tag);
      end
      chk("rnd busy", busy, m_mode != 0);
      chk("rnd rd_cnt", rd_cnt, m_rdc);
      chk("rnd wb_cnt", wb_cnt, m_wbc);
      chk("rnd underrun", wb_underrun, m_und);

      if ($urandom_range(15) == 0) stream_mode = ~stream_mode;
      bus.rd_valid   = NPE'($urandom) & NPE'($urandom);
      bus.rd_node_id = (NPE*NW)'({$urandom, $urandom});
      bus.wb_valid   = (m_mode == 1) ? ($urandom_range(15) != 0) : ($urandom_range(2) == 0);
      bus.wb_eos     = ($urandom_range(3) == 0);
      bus.wb_node_id = NW'($urandom);
      bus.wb_data    = {$urandom, $urandom};
      bank_rd_eos    = ($urandom_range(3) == 0);
      #1;

      g_wb = 0;
      g_k  = -1;
      any_rd = (bus.rd_valid != 0);
      if (m_mode == 0 && !stream_mode && !m_gap) begin
        if (bus.wb_valid && !(m_starve && any_rd)) g_wb = 1;
        else if (any_rd)
          for (int j = 0; j < NPE; j++)
            if (g_k < 0 && bus.rd_valid[(m_ptr + j) % NPE]) g_k = (m_ptr + j) % NPE;
      end
      chk("rnd rd_ready", bus.rd_ready, (g_k >= 0) ? (64'd1 << g_k) : 64'd0);
      chk("rnd wb_ready", bus.wb_ready, g_wb || (m_mode == 1));

      gap_n   = 0;
      e_valid = 0;
      if (m_mode == 0 && g_wb) begin
        e_valid = 1; e_rdwr = 1; e_node = bus.wb_node_id; e_data = bus.wb_data; e_eos = bus.wb_eos;
        if (bus.wb_eos) begin
          m_wbc = (m_wbc < CMAX) ? m_wbc + 1 : CMAX; m_starve = 1; gap_n = 1;
        end else begin
          m_wbnode = bus.wb_node_id; m_mode = 1;
        end
      end else if (m_mode == 0 && g_k >= 0) begin
        e_valid = 1; e_rdwr = 0; e_node = bus.rd_node_id[g_k*NW +: NW]; e_tag = 2'(g_k);
        m_ptr = (g_k + 1) % NPE; m_starve = 0; m_mode = 2;
      end else if (m_mode == 1) begin
        e_valid = 1; e_rdwr = 1; e_node = m_wbnode;
        if (bus.wb_valid) begin
          e_data = bus.wb_data; e_eos = bus.wb_eos;
          if (bus.wb_eos) begin
            m_wbc = (m_wbc < CMAX) ? m_wbc + 1 : CMAX; m_starve = 1; gap_n = 1; m_mode = 0;
          end
        end else begin
          e_data = '0; e_eos = 1; m_und = 1; m_starve = 1; gap_n = 1; m_mode = 0;
        end
      end else if (m_mode == 2 && bank_rd_eos) begin
        m_rdc = (m_rdc < CMAX) ? m_rdc + 1 : CMAX; m_mode = 0;
      end
      m_gap = gap_n;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fv_bank_req_arbiter.md
# fv_bank_req_arbiter

Shares one Big feature-value SRAM bank controller between `NUM_PE` Edge PE read requesters and the output-buffer write-back stream. Sits directly in front of the bank controller's `Req2Output_SRAM_Bank` request port. Serializes whole transactions: one read burst or one write-back burst at a time. Holds request fields stable for the bank's multi-cycle bursts and blocks all traffic while the bank is in iteration-streaming mode.

## Interface
Parameters:
- `NUM_PE`, default 4: number of Edge PE read requesters (`Num_Edge_PE`).
- `NODE_ID_W`, default 10: node-id width (`$clog2(Max_Node_id)`).
- `DATA_W`, default 64: feature-value line width (`FV_bandwidth`).
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `rd_valid`, in, `NUM_PE`: per-PE read request.
- `rd_node_id`, in, `NUM_PE*NODE_ID_W`: per-PE node id, packed with PE0 in the LSBs.
- `rd_ready`, out, `NUM_PE`: one-hot grant; a request transfers when `rd_valid[i] & rd_ready[i]`.
- `wb_valid`, in, 1: write-back beat valid.
- `wb_node_id`, in, `NODE_ID_W`: write-back base node.
- `wb_data`, in, `DATA_W`: write-back line.
- `wb_eos`, in, 1: last beat of the write-back burst.
- `wb_ready`, out, 1: beat accepted.
- `stream_mode`, in, 1: `Cur_Update_Iter[0]`; the bank is streaming and must not receive requests.
- `bank_rd_eos`, in, 1: `EdgePE_rd_out.eos` from the bank.
- `bank_req_valid`, out, 1: `req_pkt.valid`.
- `bank_req_rd_wr`, out, 1: `req_pkt.rd_wr` (1 = write).
- `bank_req_node_id`, out, `NODE_ID_W`: `req_pkt.Node_id`.
- `bank_req_data`, out, `DATA_W`: `req_pkt.data`.
- `bank_req_wr_eos`, out, 1: `req_pkt.wr_eos`.
- `bank_req_pe_tag`, out, `$clog2(NUM_PE)`: `req_pkt.PE_tag`.
- `busy`, out, 1: the FSM is not in IDLE.
- `wb_underrun`, out, 1: sticky error flag.
- `rd_cnt`, out, `CNT_W`: saturating count of completed reads.
- `wb_cnt`, out, `CNT_W`: saturating count of completed write-back bursts.

## Operation
- **FSM states:** IDLE, WB_BURST, RD_WAIT.
- **IDLE, grant rules:**
  - No grant while `stream_mode=1`.
  - Otherwise a write-back wins over reads, unless `rd_starve=1` and a read is pending.
  - `rd_starve` sets at the end of each write-back burst and clears on any read grant. This guarantees at least one read between consecutive write-back bursts.
- **Read arbitration:**
  - Round-robin across PEs, starting the search at `rr_ptr`.
  - On grant to PE k, `rr_ptr <= (k+1) mod NUM_PE`.
- **Read grant in IDLE:**
  - `rd_ready[k]=1` (combinational).
  - Next cycle the registered outputs are `bank_req_valid=1`, `rd_wr=0`, `node_id=rd_node_id[k]`, `pe_tag=k`. Then go to RD_WAIT.
- **RD_WAIT:**
  - `bank_req_valid` is driven 0 after the first cycle.
  - `node_id` and `pe_tag` are held, because the bank re-reads `Node_id` every cycle of the burst.
  - On `bank_rd_eos`: go to IDLE and increment `rd_cnt`.
- **Write-back grant in IDLE:**
  - `wb_ready=1` and the beat is registered to the bank with `rd_wr=1`.
  - If `wb_eos`: stay in IDLE, increment `wb_cnt`, set `rd_starve`.
  - Otherwise go to WB_BURST and latch `wb_node_id`.
- **WB_BURST:**
  - `wb_ready=1` every cycle. Each beat is registered through with the latched `node_id`.
  - A beat with `wb_eos` returns the FSM to IDLE, increments `wb_cnt` and sets `rd_starve`.
  - `wb_valid=0` mid-burst: the bank advances its address every cycle regardless. The arbiter drives `valid=1`, `data=0`, `wr_eos=1`, sets `wb_underrun`, and returns to IDLE.
- **`stream_mode` rising mid-transaction:** the current burst completes normally. Only new grants are blocked.
- **Counters:** saturate at all-ones; they do not wrap.

## Timing
- Grant-to-bank latency is 1 cycle; all `bank_req_*` outputs are registered.
- Write-back throughput is 1 beat per cycle with 1-cycle pipeline delay; `wb_eos` reaches the bank in the same cycle as its data.
- **Read occupancy:**
  - A read occupies the bank from the grant+1 cycle through the `bank_rd_eos` cycle.
  - The next grant can be made in the cycle after `bank_rd_eos`, and it reaches the bank 1 cycle later.
  - This 1-cycle gap lets the bank return to IDLE.
- After a write-back burst's eos beat reaches the bank, the next request reaches the bank no sooner than 2 cycles later (1-cycle idle gap).
- **Reset values:** all outputs 0, `state=IDLE`, `rr_ptr=0`, `rd_starve=0`, counters 0, `wb_underrun=0`. Reset mid-burst aborts the burst immediately.

## Structure
- Request/packet typedefs stay in the shared `sys_defs` package: reuse `Req2Output_SRAM_Bank` for the output bundle, with the flat ports above mapped onto it at integration.
- `NUM_PE`, `NODE_ID_W` and `DATA_W` derive from `Num_Edge_PE`, `Max_Node_id` and `FV_bandwidth`.
- Sub-module `rr_arbiter` (`NUM_PE` requests, pointer in, one-hot grant out) is instantiated once.

## Test plan
- **Single read:** PE2 requests node 12 → `rd_ready=4'b0100` that cycle; next cycle `valid=1`, `rd_wr=0`, `node_id=12`, `pe_tag=2`; `node_id` held until the `bank_rd_eos` pulse 4 cycles later; `rd_cnt=1`.
- **Round-robin:** all 4 PEs request continuously with reads completing → grant order 0,1,2,3,0.
- **Write-back priority and anti-starvation:** 3-beat write-back (node 8, data A,B,C, eos on C) and PE1 pending, with the write-back request continuing after the burst → the bank sees 3 write beats on consecutive cycles, then the PE1 read before the next write-back.
- **Stream block:** `stream_mode=1` with all requests pending → no `rd_ready`/`wb_ready` for 20 cycles; the first grant occurs the cycle after `stream_mode` falls.
- **Underrun:** `wb_valid` drops on beat 2 of a 4-beat burst → beat 2 is sent with `data=0` and `wr_eos=1`; `wb_underrun=1` stays set; FSM returns to IDLE.
- **Reset mid-read:** assert `reset` in RD_WAIT → next cycle all outputs 0, FSM IDLE, `rr_ptr=0`.
